// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank.
//   - Register address map (five 8-bit registers at 0x00..0x04)
//   - Frame geometry and bit-counter limits
//   - Receiver state encoding and frame field layout
//   - Saturating bit-counter increment helper
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // A frame is well-formed only with exactly CNT_FULL bits; the counter
    // stops at CNT_SAT so any longer frame stays distinguishable from 16.
    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        WAIT_HI = 2'd2
    } state_e;

    // Field view of the 16-bit shift register, MSB first on the wire.
    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } frame_t;

    function automatic logic [4:0] cnt_inc(input logic [4:0] cnt);
        logic [4:0] nxt;
        if (cnt >= CNT_SAT) begin
            nxt = CNT_SAT;
        end else begin
            nxt = cnt + 5'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a history
// flop so that edges of the synchronized level can be detected.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (all flops -> RESET_VAL)
//   async_in  in   asynchronous input pin
//   level     out  synchronized level (last synchronizer stage)
//   rise      out  one-cycle strobe on a 0->1 change of level
//   fall      out  one-cycle strobe on a 1->0 change of level
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    // Next values: shift the pin into the chain, remember the last level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        hist_d = sync_q[STAGES-1];
    end

    // Synchronizer and history flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0, write-only configuration port feeding the PWM peripheral.
// SCLK/COPI/nCS are oversampled on clk; a register is written only when a
// complete 16-bit write frame to a valid address is closed by nCS rising.
// Ports:
//   clk               in   system clock (only clock)
//   rst               in   synchronous active-high reset
//   sclk, copi, ncs   in   asynchronous SPI pins (ncs active-low)
//   en_reg_out_7_0    out  register 0x00
//   en_reg_out_15_8   out  register 0x01
//   en_reg_pwm_7_0    out  register 0x02
//   en_reg_pwm_15_8   out  register 0x03
//   pwm_duty_cycle    out  register 0x04
//   wr_pulse          out  one-cycle strobe per committed write
//   frame_err         out  one-cycle strobe per discarded (wrong-length) frame
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse,
    output logic       frame_err
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic sclk_level_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic ncs_level_s;
    logic ncs_rise_s;
    logic ncs_fall_s;

    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_d;
    logic                   copi_level_s;

    state_e                  state_q;
    state_e                  state_d;
    logic [4:0]              cnt_q;
    logic [4:0]              cnt_d;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   shift_d;
    logic [SETTLE_W-1:0]     settle_q;
    logic [SETTLE_W-1:0]     settle_d;
    logic [4:0][7:0]         regs_q;
    logic [4:0][7:0]         regs_d;
    logic                    wr_pulse_q;
    logic                    wr_pulse_d;
    logic                    frame_err_q;
    logic                    frame_err_d;

    frame_t frame_s;
    logic   commit_s;
    logic   discard_s;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .level    (sclk_level_s),
        .rise     (sclk_rise_s),
        .fall     (sclk_fall_s)
    );

    // nCS idles high, so its synchronizer resets to 1 to avoid a false fall.
    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_ncs (
        .clk      (clk),
        .rst      (rst),
        .async_in (ncs),
        .level    (ncs_level_s),
        .rise     (ncs_rise_s),
        .fall     (ncs_fall_s)
    );

    // COPI only needs its level, delayed exactly like SCLK so the sampled
    // data bit lines up with the detected SCLK rise.
    always_comb begin
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    end

    // COPI synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            copi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            copi_sync_q <= copi_sync_d;
        end
    end

    assign copi_level_s = copi_sync_q[SYNC_STAGES-1];
    assign frame_s      = frame_t'(shift_q);

    // Receiver FSM, bit counter, shift register and reset-settle timer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        commit_s  = 1'b0;
        discard_s = 1'b0;

        // After reset the nCS synchronizer still shows its reset value for
        // SYNC_STAGES cycles; settle_q counts those cycles down so WAIT_HI
        // knows when the synchronized level really reflects the pin.
        if (settle_q != {SETTLE_W{1'b0}}) begin
            settle_d = settle_q - SETTLE_W'(1);
        end else begin
            settle_d = settle_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 5'd0;
                if (ncs_fall_s) begin
                    state_d = RECV;
                    shift_d = {FRAME_BITS{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                // nCS rising wins over a simultaneous SCLK rise: the frame
                // has already ended, so that late edge is not shifted in.
                if (ncs_rise_s) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_FULL) begin
                        if (frame_s.wr && (frame_s.addr <= MAX_ADDR)) begin
                            commit_s = 1'b1;
                        end else begin
                            commit_s = 1'b0;
                        end
                    end else begin
                        discard_s = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_level_s};
                    cnt_d   = cnt_inc(cnt_q);
                end else begin
                    state_d = RECV;
                end
            end
            WAIT_HI: begin
                // A frame interrupted by reset is drained here silently.
                cnt_d = 5'd0;
                if (ncs_rise_s || ((settle_q == {SETTLE_W{1'b0}}) && ncs_level_s)) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Register file update and output strobes.
    always_comb begin
        regs_d      = regs_q;
        wr_pulse_d  = commit_s;
        frame_err_d = discard_s;
        if (commit_s) begin
            case (frame_s.addr)
                ADDR_EN_OUT_LO: regs_d[0] = frame_s.data;
                ADDR_EN_OUT_HI: regs_d[1] = frame_s.data;
                ADDR_EN_PWM_LO: regs_d[2] = frame_s.data;
                ADDR_EN_PWM_HI: regs_d[3] = frame_s.data;
                ADDR_DUTY:      regs_d[4] = frame_s.data;
                default:        regs_d    = regs_q;
            endcase
        end else begin
            regs_d = regs_q;
        end
    end

    // State and datapath flops. Reset lands in WAIT_HI so that a frame which
    // was in flight when reset hit is ignored up to its nCS rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_HI;
            cnt_q       <= 5'd0;
            shift_q     <= {FRAME_BITS{1'b0}};
            settle_q    <= SETTLE_W'(SYNC_STAGES);
            regs_q      <= {5{8'h00}};
            wr_pulse_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            settle_q    <= settle_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign wr_pulse        = wr_pulse_q;
    assign frame_err       = frame_err_q;

    // SCLK level and fall are not needed: mode 0 samples on rise only.
    logic unused_s;
    assign unused_s = sclk_level_s ^ sclk_fall_s;

endmodule
